axis_wrr_arbiter: RTL and testbench
===================================

AXIS_WRR_ARBITER -- requirements
Module: axis_wrr_arbiter

Interface
REQ-001 SHALL have parameter S_COUNT, default 4, meaning the number of requesting AXI stream ports (2..16).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, meaning the width of each per-port weight in packets per turn.
REQ-003 SHALL have parameter LAST_ENABLE, default 1, meaning: 1 = a turn unit is a packet (ends on tlast); 0 = a turn unit is a single beat.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_tvalid, input, S_COUNT bits: per-port request and monitor of the mux input tvalid.
REQ-007 SHALL have port s_axis_tready, input, S_COUNT bits: monitor of the mux input tready.
REQ-008 SHALL have port s_axis_tlast, input, S_COUNT bits: monitor of the mux input tlast.
REQ-009 SHALL have port cfg_weight, input, S_COUNT*WEIGHT_WIDTH bits: packets per turn for each port; port i is at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-010 SHALL have port cfg_enable, input, S_COUNT bits: per-port arbitration enable.
REQ-011 SHALL have port grant, output, S_COUNT bits: one-hot grant, registered.
REQ-012 SHALL have port grant_valid, output, 1 bit: grant is active, registered.
REQ-013 SHALL have port grant_encoded, output, $clog2(S_COUNT) bits: index of the granted port, registered.
REQ-014 SHALL have port grant_credit, output, WEIGHT_WIDTH bits: units remaining in the current turn, including the unit in progress.

Function
REQ-015 SHALL define port i as eligible when s_axis_tvalid[i], cfg_enable[i], and cfg_weight[i] != 0 are all true.
REQ-016 SHALL define ack as: grant_valid, AND grant[i], AND s_axis_tvalid[i], AND s_axis_tready[i], AND (s_axis_tlast[i] when LAST_ENABLE=1, else 1).
REQ-017 SHALL have exactly two states, IDLE and BUSY; grant, grant_encoded and grant_valid change only on a transition between them.
REQ-018 IDLE behaviour when turn_active is set and the turn port is eligible: SHALL re-grant the turn port.
REQ-019 IDLE behaviour otherwise: SHALL clear turn_active and grant the first eligible port, searching upward from rr_ptr with modulo-S_COUNT wrap.
REQ-020 SHALL, at the start of each new turn, load credit with cfg_weight of the granted port and set turn_active.
REQ-021 The IDLE-to-BUSY transition SHALL set grant_valid=1 on the next edge (1-cycle latency from request) and SHALL stay in IDLE when no port is eligible.
REQ-022 BUSY behaviour: SHALL hold the grant with no regard to changes in tvalid, cfg_enable or cfg_weight until ack.
REQ-023 Multi-beat packets and tready stalls SHALL never release the grant.
REQ-024 On ack SHALL: go to IDLE; set grant_valid=0 and grant=0 on the next edge, holding grant_encoded; and decrement credit.
REQ-025 If the decremented credit is 0, SHALL clear turn_active and set rr_ptr = (granted index + 1) mod S_COUNT.
REQ-026 SHALL therefore keep grant_valid low for at least 1 cycle between consecutive grants, including a re-grant of the same port.
REQ-027 Turn-port drop: if the turn port is not eligible in IDLE while credit > 0, SHALL forfeit the remaining credit, set rr_ptr = (turn port + 1) mod S_COUNT, and arbitrate in the same cycle (no deficit carry-over).
REQ-028 SHALL sample cfg_weight only at turn start; a mid-turn change of cfg_weight takes effect on that port's next turn.
REQ-029 SHALL ignore ack-like handshakes on non-granted ports.
REQ-030 SHALL keep grant_credit equal to credit while turn_active is set and 0 otherwise.
REQ-031 SHALL guarantee that grant is always one-hot when grant_valid=1 and all-zero otherwise.

Reset
REQ-032 SHALL, while rst=1 (asynchronously, without waiting for clk), force: state IDLE; grant=0; grant_valid=0; grant_encoded=0; grant_credit=0; credit=0; rr_ptr=0; turn_active=0.
REQ-033 Reset mid-packet SHALL drop the grant immediately.
REQ-034 After rst is released, the first grant SHALL search upward from port 0.

Verification
REQ-035 Reset check: assert rst mid-cycle while grant_valid=1 -> grant, grant_valid and grant_credit are 0 before the next clk edge; after release with all ports requesting, the first grant is port 0 two edges later.
REQ-036 Weighted rotation: S_COUNT=4, weights {1,2,1,1}, all ports enabled and requesting, single-beat tlast=1 packets, tready=1 -> grant_encoded sequence 0,1,1,2,3,0,1,1, with grant_valid low for 1 cycle between grants; grant_credit reads 2 then 1 on the two port-1 grants.
REQ-037 Skip rule: weights {1,0,1,1}, or cfg_enable[1]=0 -> sequence 0,2,3,0; port 1 is never granted.
REQ-038 Forfeit rule: port 1 weight 3 deasserts tvalid after its first packet -> next grant is port 2 and port 1 never receives the remaining 2 credits.
REQ-039 Packet hold: port 0 sends a 5-beat packet with tready toggling every cycle and cfg_enable[0] cleared at beat 2 -> grant[0] is held until the tlast handshake, then grant_valid=0 on the next cycle.
REQ-040 Mid-turn config: port 2 weight changes 1->3 while port 2 is in BUSY -> current turn ends after 1 packet; port 2's following turn yields 3 packets.

Source files
------------

// File: rtl/axis_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_wrr_arbiter
// Weighted round-robin arbiter for a bank of AXI-stream sources. Each port
// gets a turn of up to cfg_weight[i] units (packets, or beats when
// LAST_ENABLE=0). Between any two grants the arbiter goes back to IDLE for at
// least one cycle. A turn ends early if its port stops being eligible, and
// the unused credit is lost.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   s_axis_tvalid     : per-port request / tvalid monitor
//   s_axis_tready     : tready monitor of the downstream mux inputs
//   s_axis_tlast      : tlast monitor of the downstream mux inputs
//   cfg_weight        : per-port units per turn, port i at [i*WW +: WW]
//   cfg_enable        : per-port arbitration enable
//   grant             : registered one-hot grant
//   grant_valid       : registered grant-active flag
//   grant_encoded     : registered index of the granted port
//   grant_credit      : units left in the current turn, including the one
//                       in progress (0 when no turn is active)
// ---------------------------------------------------------------------------
module axis_wrr_arbiter #(
    parameter int S_COUNT      = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int LAST_ENABLE  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [S_COUNT-1:0]                s_axis_tvalid,
    input  logic [S_COUNT-1:0]                s_axis_tready,
    input  logic [S_COUNT-1:0]                s_axis_tlast,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0]   cfg_weight,
    input  logic [S_COUNT-1:0]                cfg_enable,
    output logic [S_COUNT-1:0]                grant,
    output logic                              grant_valid,
    output logic [$clog2(S_COUNT)-1:0]        grant_encoded,
    output logic [WEIGHT_WIDTH-1:0]           grant_credit
);

    localparam int IW = $clog2(S_COUNT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                    r_state;
    logic [S_COUNT-1:0]        r_grant;
    logic                      r_grant_valid;
    logic [IW-1:0]             r_grant_encoded;
    logic [WEIGHT_WIDTH-1:0]   r_credit;
    logic [IW-1:0]             r_rr_ptr;
    logic                      r_turn_active;

    logic [S_COUNT-1:0]        w_elig;
    logic [2*S_COUNT-1:0]      w_elig2;
    logic [S_COUNT-1:0]        w_last;
    logic                      w_ack;
    logic                      w_turn_ok;
    logic [IW-1:0]             w_next_ptr;
    logic [IW-1:0]             w_base;
    logic                      w_found;
    logic [IW-1:0]             w_pick;
    logic [WEIGHT_WIDTH-1:0]   w_pick_weight;

    // Index successor with wrap at S_COUNT (S_COUNT need not be a power of 2).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(S_COUNT - 1)) begin
            return '0;
        end else begin
            return v + IW'(1);
        end
    endfunction

    // A port may only win when it requests, is enabled and has a non-zero weight.
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_elig
        assign w_elig[gi] = s_axis_tvalid[gi] & cfg_enable[gi] &
                            (cfg_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] != {WEIGHT_WIDTH{1'b0}});
    end

    assign w_last     = (LAST_ENABLE != 0) ? s_axis_tlast : {S_COUNT{1'b1}};
    assign w_ack      = r_grant_valid & (|(r_grant & s_axis_tvalid & s_axis_tready & w_last));
    assign w_turn_ok  = w_elig[r_grant_encoded];
    assign w_next_ptr = wrap_inc(r_grant_encoded);
    // A dropped turn restarts the search just past the dropped port.
    assign w_base     = r_turn_active ? w_next_ptr : r_rr_ptr;
    // Doubled vector turns the wrapping search into a plain linear scan.
    assign w_elig2    = {w_elig, w_elig};

    // First eligible port at or above w_base, wrapping modulo S_COUNT.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            if (!w_found && w_elig2[int'(w_base) + k]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(w_base) + k) % S_COUNT);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_pick_weight = cfg_weight[int'(w_pick)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    // Arbitration FSM: IDLE picks or re-grants, BUSY holds until the unit ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_encoded <= '0;
            r_credit        <= '0;
            r_rr_ptr        <= '0;
            r_turn_active   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_turn_active && w_turn_ok) begin
                        // Continue the running turn; credit is unchanged.
                        r_state       <= ST_BUSY;
                        r_grant       <= S_COUNT'(1) << r_grant_encoded;
                        r_grant_valid <= 1'b1;
                    end else begin
                        r_turn_active <= 1'b0;
                        if (r_turn_active) begin
                            // Turn port dropped out: forfeit what is left.
                            r_rr_ptr <= w_next_ptr;
                            r_credit <= '0;
                        end
                        if (w_found) begin
                            r_state         <= ST_BUSY;
                            r_grant         <= S_COUNT'(1) << w_pick;
                            r_grant_valid   <= 1'b1;
                            r_grant_encoded <= w_pick;
                            r_credit        <= w_pick_weight;
                            r_turn_active   <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_ack) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_credit      <= r_credit - WEIGHT_WIDTH'(1);
                        if (r_credit == WEIGHT_WIDTH'(1)) begin
                            r_turn_active <= 1'b0;
                            r_rr_ptr      <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;
    assign grant_credit  = r_turn_active ? r_credit : {WEIGHT_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
module tb_axis_wrr_arbiter;

    localparam int S  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [S-1:0]  tvalid, tready, tlast, en;
    logic [S*WW-1:0] wt;
    logic [S-1:0]  grant;
    logic          gv;
    logic [1:0]    genc;
    logic [WW-1:0] gcred;

    int checks = 0;
    int errors = 0;

    axis_wrr_arbiter #(.S_COUNT(S), .WEIGHT_WIDTH(WW), .LAST_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .cfg_weight(wt), .cfg_enable(en),
        .grant(grant), .grant_valid(gv), .grant_encoded(genc), .grant_credit(gcred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = '0; tready = '0; tlast = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the next rising edge of grant_valid, seen at a negedge.
    task automatic collect(output int port, output int cred);
        logic prev;
        prev = gv;
        port = -1; cred = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (gv && !prev) begin
                port = int'(genc); cred = int'(gcred);
                return;
            end
            prev = gv;
        end
        chk("grant_timeout", 0, 1);
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_busy, m_inturn;
    int m_port, m_left, m_ptr;

    function automatic int wof(input int p);
        return int'(wt[p*WW +: WW]);
    endfunction

    function automatic bit elig(input int p);
        return tvalid[p] && en[p] && (wof(p) != 0);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_inturn = 0; m_port = 0; m_left = 0; m_ptr = 0;
    endtask

    // Advance one clock given the inputs that will be present at the edge.
    task automatic model_step();
        int start;
        if (!m_busy) begin
            if (m_inturn && elig(m_port)) begin
                m_busy = 1;
            end else begin
                start = m_inturn ? (m_port + 1) % S : m_ptr;
                if (m_inturn) m_ptr = start;
                m_inturn = 0; m_left = 0;
                for (int k = 0; k < S; k++) begin
                    if (!m_busy && elig((start + k) % S)) begin
                        m_port = (start + k) % S;
                        m_left = wof(m_port);
                        m_inturn = 1; m_busy = 1;
                    end
                end
            end
        end else if (tvalid[m_port] && tready[m_port] && tlast[m_port]) begin
            m_busy = 0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_inturn = 0;
                m_ptr = (m_port + 1) % S;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [S*WW-1:0] w;
        logic [S-1:0]    e;
        int              n;
        int              seq[8];
        int              cred[8];
    } vec_t;

    vec_t vecs[3];

    initial begin
        int p, c;
        int beats;
        bit done;
        logic trdy;

        rst = 1'b1; tvalid = '0; tready = '0; tlast = '0;
        en = '1; wt = {4'd1, 4'd1, 4'd1, 4'd1};

        vecs[0].w = {4'd1, 4'd1, 4'd2, 4'd1}; vecs[0].e = 4'b1111; vecs[0].n = 8;
        vecs[0].seq = '{0, 1, 1, 2, 3, 0, 1, 1}; vecs[0].cred = '{1, 2, 1, 1, 1, 1, 2, 1};
        vecs[1].w = {4'd1, 4'd1, 4'd0, 4'd1}; vecs[1].e = 4'b1111; vecs[1].n = 4;
        vecs[1].seq = '{0, 2, 3, 0, 0, 0, 0, 0}; vecs[1].cred = '{1, 1, 1, 1, 0, 0, 0, 0};
        vecs[2].w = {4'd1, 4'd1, 4'd1, 4'd1}; vecs[2].e = 4'b1101; vecs[2].n = 4;
        vecs[2].seq = '{0, 2, 3, 0, 0, 0, 0, 0}; vecs[2].cred = '{1, 1, 1, 1, 0, 0, 0, 0};

        // Reset state
        do_reset();
        chk("rst_gv", int'(gv), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_enc", int'(genc), 0);
        chk("rst_cred", int'(gcred), 0);

        // Table-driven rotation / skip sequences
        for (int v = 0; v < 3; v++) begin
            wt = vecs[v].w; en = vecs[v].e;
            do_reset();
            tvalid = '1; tready = '1; tlast = '1;
            for (int g = 0; g < vecs[v].n; g++) begin
                collect(p, c);
                chk($sformatf("tbl%0d_port%0d", v, g), p, vecs[v].seq[g]);
                chk($sformatf("tbl%0d_cred%0d", v, g), c, vecs[v].cred[g]);
            end
        end

        // Asynchronous reset mid-grant, then first grant from port 0
        wt = {4'd1, 4'd1, 4'd1, 4'd1}; en = '1;
        do_reset();
        tvalid = '1; tready = '1; tlast = '1;
        collect(p, c); collect(p, c);
        @(negedge clk); tready = '0;
        collect(p, c);
        chk("pre_rst_port", p, 2);
        @(posedge clk); #2;
        chk("pre_rst_gv", int'(gv), 1);
        rst = 1'b1; #1;
        chk("async_rst_gv", int'(gv), 0);
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_cred", int'(gcred), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("post_rst_gv", int'(gv), 1);
        chk("post_rst_enc", int'(genc), 0);

        // Forfeit: port 1 weight 3 drops out after its first packet
        wt = {4'd1, 4'd1, 4'd3, 4'd1}; en = '1;
        do_reset();
        tvalid = '1; tready = '1; tlast = '1;
        collect(p, c); chk("ff_first", p, 0);
        collect(p, c); chk("ff_p1", p, 1); chk("ff_p1_cred", c, 3);
        @(negedge clk); tvalid[1] = 1'b0;
        collect(p, c); chk("ff_next", p, 2);
        tvalid[1] = 1'b1;
        collect(p, c); chk("ff_p3", p, 3);
        collect(p, c); chk("ff_p0", p, 0);
        collect(p, c); chk("ff_p1_again", p, 1); chk("ff_p1_fresh_cred", c, 3);

        // Packet hold: 5-beat packet, toggling tready, enable cleared at beat 2
        wt = {4'd1, 4'd1, 4'd1, 4'd1}; en = '1;
        do_reset();
        tvalid = 4'b0001; tready = '0; tlast = '0;
        collect(p, c); chk("hold_port", p, 0);
        beats = 0; done = 0; trdy = 1'b0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            trdy = ~trdy;
            tready = {3'b000, trdy};
            tlast = {3'b000, (beats == 4)};
            en[0] = (beats < 2);
            @(posedge clk); #1;
            if (trdy) beats++;
            if (beats == 5) begin
                chk("hold_release_gv", int'(gv), 0);
                done = 1;
            end else begin
                chk($sformatf("hold_c%0d", cyc), int'(grant), 1);
            end
        end
        chk("hold_done", int'(done), 1);
        @(negedge clk); tvalid = '0; en = '1;

        // Mid-turn weight change on port 2
        wt = {4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        tvalid = 4'b1100; tready = '0; tlast = '1;
        collect(p, c); chk("mt_p2", p, 2); chk("mt_p2_cred", c, 1);
        @(negedge clk); wt[2*WW +: WW] = 4'd3; tready = '1;
        collect(p, c); chk("mt_p3", p, 3);
        collect(p, c); chk("mt_p2b", p, 2); chk("mt_p2b_cred", c, 3);
        collect(p, c); chk("mt_p2c", p, 2); chk("mt_p2c_cred", c, 2);
        collect(p, c); chk("mt_p2d", p, 2); chk("mt_p2d_cred", c, 1);
        collect(p, c); chk("mt_p3b", p, 3);

        // Randomized run against the reference model
        wt = {4'd1, 4'd3, 4'd2, 4'd1}; en = '1;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_gv", int'(gv), int'(m_busy));
            chk("rnd_grant", int'(grant), m_busy ? (1 << m_port) : 0);
            chk("rnd_enc", int'(genc), m_port);
            chk("rnd_cred", int'(gcred), m_inturn ? m_left : 0);
            tvalid = S'($urandom) | S'($urandom);
            tready = S'($urandom) | S'($urandom);
            tlast  = S'($urandom);
            if (cyc % 37 == 0) en = S'($urandom) | S'($urandom) | S'($urandom);
            if (cyc % 23 == 0) begin
                for (int i = 0; i < S; i++) wt[i*WW +: WW] = WW'($urandom_range(0, 3));
            end
            model_step();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
